shift_add_ctrl: RTL and testbench



---
 rtl/shift_add_ctrl.sv | 96 +++++++++
 tb/tb_shift_add_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_ctrl.sv
// Radix-2 shift-add multiplier sequencer for unsigned WxW operands.
// Drives an external 2W-bit product register and iterates on its registered contents.
module shift_add_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  input  logic [2*W-1:0] prod_q,
  output logic [W-1:0]   inh,
  output logic [W-1:0]   inl,
  output logic           loadh,
  output logic           loadl,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [W-1:0]    mcand_r;
  logic [W-1:0]    mplier_r;

  logic [W-1:0]    addend;
  logic [W:0]      sum;
  logic [2*W-1:0]  nxt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= StIdle;
      cnt      <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            mcand_r  <= mcand;
            mplier_r <= mplier;
            state    <= StLoad;
          end
        end
        StLoad: begin
          cnt   <= '0;
          state <= StRun;
        end
        StRun: begin
          cnt <= cnt + CntW'(1);
          if (cnt == CntW'(W - 1)) state <= StDone;
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // The carry out of the add becomes the MSB of the shifted partial product.
  always_comb begin
    addend = prod_q[0] ? mcand_r : '0;
    sum    = {1'b0, prod_q[2*W-1:W]} + {1'b0, addend};
    nxt    = {sum, prod_q[W-1:1]};
  end

  always_comb begin
    inh   = '0;
    inl   = '0;
    loadh = 1'b0;
    loadl = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      StIdle: ;
      StLoad: begin
        inl   = mplier_r;
        loadh = 1'b1;
        loadl = 1'b1;
        busy  = 1'b1;
      end
      StRun: begin
        inh   = nxt[2*W-1:W];
        inl   = nxt[W-1:0];
        loadh = 1'b1;
        loadl = 1'b1;
        busy  = 1'b1;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Scoreboard bench for shift_add_ctrl with a behavioural product register in the loop.
// Stimulus queues expected operations; a negedge monitor checks every cycle of each one.
module tb_shift_add_ctrl;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           clear;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   inh;
  logic [W-1:0]   inl;
  logic           loadh;
  logic           loadl;
  logic           busy;
  logic           done;

  shift_add_ctrl #(.W(W)) dut (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .prod_q (prod_q),
    .inh    (inh),
    .inl    (inl),
    .loadh  (loadh),
    .loadl  (loadl),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) prod_q <= '0;
    else begin
      if (loadh) prod_q[2*W-1:W] <= inh;
      if (loadl) prod_q[W-1:0]   <= inl;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic [2*W-1:0] prod;
    int             acc;
  } op_t;

  op_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  last_acc;
  logic [2*W-1:0] last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: cycle j after the accept edge selects LOAD (0), RUN (1..W) or DONE (W+1).
  int             j;
  logic [2*W-1:0] p;
  logic [W:0]     s;
  always @(negedge clk) begin
    if (!clear) begin
      chk("strobes_equal", 32'(loadh), 32'(loadl));
      if (q.size() == 0) begin
        chk("idle_outputs", 32'({busy, done, loadh, loadl}), 32'h0);
      end else begin
        j = cyc - q[0].acc;
        if (j < 0) begin
          chk("pre_accept_idle", 32'({busy, done, loadh, loadl}), 32'h0);
        end else if (j == 0) begin
          p = {{W{1'b0}}, q[0].mp};
          chk("load_strobes", 32'({busy, done, loadh, loadl}), 32'b1011);
          chk("load_data", 32'({inh, inl}), 32'(p));
        end else if (j <= int'(W)) begin
          s = {1'b0, p[2*W-1:W]} + {1'b0, (p[0] ? q[0].mc : {W{1'b0}})};
          p = {s, p[W-1:1]};
          chk("run_strobes", 32'({busy, done, loadh, loadl}), 32'b1011);
          chk("run_data", 32'({inh, inl}), 32'(p));
        end else begin
          chk("done_strobes", 32'({busy, done, loadh, loadl}), 32'b0100);
          chk("product", 32'(prod_q), 32'(q[0].prod));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] mc, input logic [W-1:0] mp,
                       input logic [2*W-1:0] exp);
    op_t e;
    @(negedge clk);
    start  = 1'b1;
    mcand  = mc;
    mplier = mp;
    e.mc = mc; e.mp = mp; e.prod = exp; e.acc = cyc + 1;
    q.push_back(e);
    last_acc = e.acc;
    last_exp = exp;
    @(negedge clk);
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("completion_timeout", 32'(q.size()), 32'h0);
      q.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp,
                        input logic [2*W-1:0] exp);
    issue(mc, mp, exp);
    wait_empty();
    repeat (3) @(negedge clk);
    chk("product_hold", 32'(prod_q), 32'(exp));
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) chk("wait_cycle_timeout", 32'(cyc), 32'(target));
  endtask

  initial begin
    int base;
    clear  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({inh, inl, busy, done, loadh, loadl}), 32'h0);
    chk("reset_prod", 32'(prod_q), 32'h0);
    clear = 1'b0;
    repeat (2) @(negedge clk);

    run_op(8'd13, 8'd11, 16'h008F);
    run_op(8'd255, 8'd255, 16'hFE01);
    run_op(8'd0, 8'd200, 16'h0000);
    run_op(8'd200, 8'd1, 16'h00C8);
    run_op(8'd1, 8'd255, 16'h00FF);

    // Start requests during RUN and during DONE must be dropped.
    issue(8'd13, 8'd11, 16'h008F);
    wait_cyc(last_acc + 3);
    start = 1'b1; mcand = 8'd7; mplier = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(last_acc + int'(W) + 1);
    start = 1'b1; mcand = 8'd7; mplier = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (4) @(negedge clk);
    chk("ignored_start_result", 32'(prod_q), 32'h008F);

    // Asynchronous clear landing between edges in the 4th RUN cycle.
    issue(8'd13, 8'd11, 16'h008F);
    repeat (4) @(posedge clk);
    #2;
    clear = 1'b1;
    q.delete();
    #1;
    chk("clear_outputs", 32'({busy, done, loadh, loadl}), 32'h0);
    chk("clear_data", 32'({inh, inl}), 32'h0);
    chk("clear_prod", 32'(prod_q), 32'h0);
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    run_op(8'd3, 8'd5, 16'h000F);

    // start held high: accepts spaced W+3 edges apart.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'd6;
    mplier = 8'd7;
    base   = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      op_t e;
      e.mc = 8'd6; e.mp = 8'd7; e.prod = 16'h002A; e.acc = base + i * int'(W + 3);
      q.push_back(e);
    end
    wait_cyc(base + 2 * int'(W + 3) + int'(W) + 2);
    start = 1'b0;
    wait_empty();
    repeat (4) @(negedge clk);
    chk("back_to_back_final", 32'(prod_q), 32'h002A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
